// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: two cache-side read request ports plus the shared AXI AR/R channel.
interface axi_rd_arbiter_if;
  logic [31:0] m0_araddr, m1_araddr;
  logic [7:0] m0_arlen, m1_arlen;
  logic m0_arvalid, m1_arvalid, m0_arready, m1_arready;
  logic [31:0] m0_rdata, m1_rdata;
  logic m0_rvalid, m1_rvalid, m0_rlast, m1_rlast, m0_rready, m1_rready;
  logic [3:0] arid;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arvalid, arready;
  logic [3:0] rid;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rlast, rvalid, rready;
  modport slave (
    input m0_araddr, m1_araddr, m0_arlen, m1_arlen, m0_arvalid, m1_arvalid, m0_rready, m1_rready,
    input arready, rid, rdata, rresp, rlast, rvalid,
    output m0_arready, m1_arready, m0_rdata, m1_rdata, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready
  );
  modport master (
    output m0_araddr, m1_araddr, m0_arlen, m1_arlen, m0_arvalid, m1_arvalid, m0_rready, m1_rready,
    output arready, rid, rdata, rresp, rlast, rvalid,
    input m0_arready, m1_arready, m0_rdata, m1_rdata, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast,
    input arid, araddr, arlen, arsize, arburst, arvalid, rready
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI4 read channel between i-cache (m0) and d-cache (m1), one burst at a time.
module axi_rd_arbiter #(
  parameter bit RR_EN = 1'b1,
  parameter logic [2:0] ARSIZE = 3'd2,
  parameter logic [1:0] ARBURST = 2'd1
) (
  input logic clk,
  input logic rst,
  axi_rd_arbiter_if.slave bus,
  output logic busy_o,
  output logic proto_err_o
);
  localparam logic [1:0] IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2;
  logic [1:0] state_q, state_d;
  logic grant_q, grant_d, last_q, last_d, err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0] len_q, len_d, cnt_q, cnt_d;
  logic start, pick, in_data, ar_hs, r_hs;
  assign in_data = state_q == DATA;
  assign ar_hs = state_q == ADDR && bus.arready;
  assign bus.rready = in_data && (grant_q ? bus.m1_rready : bus.m0_rready);
  assign r_hs = bus.rready && bus.rvalid;
  // last_q remembers the previous winner so a tie goes to the other master
  always_comb begin
    start = state_q == IDLE && (bus.m0_arvalid || bus.m1_arvalid);
    pick = (bus.m0_arvalid && bus.m1_arvalid) ? (RR_EN && !last_q) : bus.m1_arvalid;
    state_d = start ? ADDR : ar_hs ? DATA : (r_hs && bus.rlast) ? IDLE : state_q;
    grant_d = start ? pick : grant_q;
    last_d = start ? pick : last_q;
    addr_d = start ? (pick ? bus.m1_araddr : bus.m0_araddr) : addr_q;
    len_d = start ? (pick ? bus.m1_arlen : bus.m0_arlen) : len_q;
    cnt_d = start ? 8'd0 : r_hs ? cnt_q + 8'd1 : cnt_q;
    err_d = err_q | (r_hs && ((bus.rlast != (cnt_q == len_q)) || bus.rid != {3'b0, grant_q} || bus.rresp != 2'd0));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q <= 1'b1;
      addr_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      addr_q <= addr_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign bus.arvalid = state_q == ADDR;
  assign bus.arid = {3'b0, grant_q};
  assign bus.araddr = addr_q;
  assign bus.arlen = len_q;
  assign bus.arsize = ARSIZE;
  assign bus.arburst = ARBURST;
  assign bus.m0_arready = ar_hs && !grant_q;
  assign bus.m1_arready = ar_hs && grant_q;
  assign bus.m0_rdata = bus.rdata;
  assign bus.m1_rdata = bus.rdata;
  assign bus.m0_rvalid = in_data && !grant_q && bus.rvalid;
  assign bus.m1_rvalid = in_data && grant_q && bus.rvalid;
  assign bus.m0_rlast = in_data && !grant_q && bus.rlast;
  assign bus.m1_rlast = in_data && grant_q && bus.rlast;
  assign busy_o = state_q != IDLE;
  assign proto_err_o = err_q;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: random cache masters and AXI slave driving a round-robin (u[0]) and a fixed-priority (u[1]) arbiter.
module tb_axi_rd_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0, phase = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input int inst, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL u%0d %s actual=%0h required=%0h t=%0t", inst, name, act, exp, $time);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : u
    axi_rd_arbiter_if bus();
    logic busy, perr;
    int own = -1, lastw = 1, beats = 0, req_cyc = -1, av_cyc = -1;
    int out_act = 0, s_beat = 0, s_kind = 0, ar_delay = 0, first_err = 1;
    logic issued = 1'b0, perr_m = 1'b0;
    logic [31:0] m_addr = '0, first_addr = '0;
    logic [7:0] m_len = '0, s_len = '0, first_len = '0;
    logic [3:0] s_id = '0;
    int grants[$];
    axi_rd_arbiter #(.RR_EN(g == 0)) dut (.clk(clk), .rst(rst), .bus(bus), .busy_o(busy), .proto_err_o(perr));
    // stimulus: both cache masters and the AXI slave; phases 0/2 force ties with an always-ready slave
    initial begin
      logic [1:0] sak;
      logic srst, sav, sar, sr, srl, rnd;
      logic [7:0] slen;
      logic [3:0] sid;
      logic mv[2];
      logic [31:0] ma[2];
      logic [7:0] ml[2];
      mv = '{1'b0, 1'b0};
      ma = '{32'd0, 32'd0};
      ml = '{8'd0, 8'd0};
      bus.m0_arvalid = 0; bus.m1_arvalid = 0; bus.m0_araddr = 0; bus.m1_araddr = 0;
      bus.m0_arlen = 0; bus.m1_arlen = 0; bus.m0_rready = 0; bus.m1_rready = 0;
      bus.arready = 0; bus.rvalid = 0; bus.rlast = 0; bus.rid = 0; bus.rresp = 0; bus.rdata = 0;
      forever begin
        @(negedge clk);
        srst = rst;
        sak = {bus.m1_arready, bus.m0_arready};
        sav = bus.arvalid;
        sar = bus.arvalid && bus.arready;
        sr = bus.rvalid && bus.rready;
        srl = bus.rlast;
        slen = bus.arlen;
        sid = bus.arid;
        @(posedge clk);
        #2;
        rnd = phase % 2 == 1;
        if (srst) begin
          mv = '{1'b0, 1'b0};
          out_act = 0;
          ar_delay = 0;
        end else begin
          for (int k = 0; k < 2; k++) begin
            if (sak[k]) mv[k] = 1'b0;
            if (mv[k] && rnd && $urandom_range(0, 63) == 0) mv[k] = 1'b0;
            if (!mv[k] && (!rnd || $urandom_range(0, 3) == 0)) begin
              mv[k] = 1'b1;
              ma[k] = $urandom & 32'hFFFF_FFFC;
              ml[k] = 8'((1 << $urandom_range(0, 4)) - 1);
              if (k == 0 && req_cyc < 0) begin
                ma[k] = 32'h1FC0_0000;
                ml[k] = 8'd7;
                req_cyc = cyc;
              end
            end
          end
          if (sar) begin
            out_act = 1;
            s_len = slen;
            s_id = sid;
            s_beat = 0;
            s_kind = phase != 3 ? 0 : first_err != 0 ? 1 : $urandom_range(0, 9) < 5 ? 0 : int'($urandom_range(1, 4));
            if (phase == 3) first_err = 0;
            ar_delay = $urandom_range(0, 6);
          end else if (sr) begin
            s_beat++;
            if (srl) out_act = 0;
          end else if (sav && ar_delay > 0) ar_delay--;
        end
        bus.m0_arvalid = mv[0]; bus.m0_araddr = ma[0]; bus.m0_arlen = ml[0];
        bus.m1_arvalid = mv[1]; bus.m1_araddr = ma[1]; bus.m1_arlen = ml[1];
        bus.m0_rready = !rnd || $urandom_range(0, 3) != 0;
        bus.m1_rready = !rnd || $urandom_range(0, 3) != 0;
        bus.arready = !rnd || ar_delay == 0;
        bus.rdata = $urandom;
        if (out_act != 0) begin
          bus.rvalid = !rnd || $urandom_range(0, 2) != 0;
          bus.rlast = s_kind == 1 ? s_beat == (s_len > 3 ? 3 : int'(s_len)) :
                      s_kind == 2 ? s_beat == int'(s_len) + 1 : s_beat == int'(s_len);
          bus.rresp = (s_kind == 3 || (s_kind == 1 && s_len <= 3)) ? 2'b10 : 2'b00;
          bus.rid = s_kind == 4 ? s_id ^ 4'd1 : s_id;
        end else begin
          bus.rvalid = rnd && $urandom_range(0, 7) == 0;
          bus.rlast = 1'($urandom_range(0, 1));
          bus.rid = 4'($urandom_range(0, 15));
          bus.rresp = 2'($urandom_range(0, 3));
        end
      end
    end
    // reference model: one outstanding transaction (owner, address issued, beats seen)
    always @(negedge clk) begin
      logic av, dat, rr;
      int w;
      av = own >= 0 && !issued;
      dat = own >= 0 && issued;
      rr = dat && (own == 1 ? bus.m1_rready : bus.m0_rready);
      if (bus.arvalid && av_cyc < 0) begin
        av_cyc = cyc;
        first_addr = bus.araddr;
        first_len = bus.arlen;
      end
      chk(g, "arvalid", bus.arvalid, av);
      if (av) begin
        chk(g, "araddr", bus.araddr, m_addr);
        chk(g, "arlen", bus.arlen, m_len);
        chk(g, "arid", bus.arid, own);
      end
      chk(g, "arsize", bus.arsize, 3'd2);
      chk(g, "arburst", bus.arburst, 2'd1);
      chk(g, "m0_arready", bus.m0_arready, av && bus.arready && own == 0);
      chk(g, "m1_arready", bus.m1_arready, av && bus.arready && own == 1);
      chk(g, "rready", bus.rready, rr);
      chk(g, "m0_rvalid", bus.m0_rvalid, dat && own == 0 && bus.rvalid);
      chk(g, "m1_rvalid", bus.m1_rvalid, dat && own == 1 && bus.rvalid);
      chk(g, "m0_rlast", bus.m0_rlast, dat && own == 0 && bus.rlast);
      chk(g, "m1_rlast", bus.m1_rlast, dat && own == 1 && bus.rlast);
      chk(g, "m0_rdata", bus.m0_rdata, bus.rdata);
      chk(g, "m1_rdata", bus.m1_rdata, bus.rdata);
      chk(g, "busy", busy, own >= 0);
      chk(g, "proto_err", perr, perr_m);
      if (rst) begin
        own = -1; issued = 0; beats = 0; lastw = 1; perr_m = 0;
      end else if (own < 0) begin
        if (bus.m0_arvalid || bus.m1_arvalid) begin
          w = (bus.m0_arvalid && bus.m1_arvalid) ? (g == 0 ? 1 - lastw : 0) : (bus.m1_arvalid ? 1 : 0);
          own = w;
          lastw = w;
          m_addr = w == 1 ? bus.m1_araddr : bus.m0_araddr;
          m_len = w == 1 ? bus.m1_arlen : bus.m0_arlen;
          beats = 0;
          issued = 0;
          grants.push_back(w);
        end
      end else if (!issued) begin
        if (bus.arready) issued = 1;
      end else if (bus.rvalid && rr) begin
        if ((bus.rlast != (beats == int'(m_len))) || bus.rid != 4'(own) || bus.rresp != 2'd0) perr_m = 1;
        beats = (beats + 1) % 256;
        if (bus.rlast) own = -1;
      end
    end
  end
  initial begin
    int n, b0, b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (70) @(posedge clk);
    chk(0, "p0_grant_count", u[0].grants.size() >= 3, 1);
    chk(1, "p0_grant_count", u[1].grants.size() >= 3, 1);
    chk(0, "rr_tie_sequence", u[0].grants[0] * 100 + u[0].grants[1] * 10 + u[0].grants[2], 10);
    chk(1, "fixed_tie_sequence", u[1].grants[0] * 100 + u[1].grants[1] * 10 + u[1].grants[2], 0);
    chk(0, "first_araddr", u[0].first_addr, 32'h1FC0_0000);
    chk(0, "first_arlen", u[0].first_len, 8'd7);
    chk(0, "first_latency", u[0].av_cyc - u[0].req_cyc, 1);
    chk(1, "first_latency", u[1].av_cyc - u[1].req_cyc, 1);
    chk(0, "p0_proto_err", u[0].perr, 0);
    chk(1, "p0_proto_err", u[1].perr, 0);
    phase = 1;
    repeat (800) @(posedge clk);
    chk(0, "p1_proto_err", u[0].perr, 0);
    chk(1, "p1_proto_err", u[1].perr, 0);
    #1;
    n = 0;
    while (!(u[0].out_act != 0 && u[0].s_beat == 4) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(0, "beat4_reached", n < 3000, 1);
    rst = 1'b1;
    phase = 2;
    @(posedge clk);
    #1 rst = 1'b0;
    b0 = u[0].grants.size();
    b1 = u[1].grants.size();
    @(negedge clk);
    chk(0, "rst_busy", u[0].busy, 0);
    chk(0, "rst_rready", u[0].bus.rready, 0);
    chk(1, "rst_busy", u[1].busy, 0);
    chk(1, "rst_rready", u[1].bus.rready, 0);
    repeat (70) @(posedge clk);
    chk(0, "rst_grant_count", u[0].grants.size() >= b0 + 2, 1);
    chk(0, "rst_rr_ties", u[0].grants[b0] * 10 + u[0].grants[b0 + 1], 1);
    chk(1, "rst_fixed_ties", u[1].grants[b1] * 10 + u[1].grants[b1 + 1], 0);
    phase = 3;
    repeat (800) @(posedge clk);
    chk(0, "p3_proto_err", u[0].perr, 1);
    chk(1, "p3_proto_err", u[1].perr, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
